inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  PC generator and instruction fetcher directly upstream of the fetch/decode stage. Issues one
//  word request at a time to instruction memory and buffers {pc, instr} pairs in a small FIFO.
//  Presents the FIFO head to decode as instruction + inst_fetch_pc.
//  Applies branch/jump redirects from execute and drops stale in-flight responses.
// PARAMETERS
//  RESET       32'h0000_0000  PC value after reset
//  FIFO_DEPTH  2              fetch buffer entries; power of 2, >=2
//  NOP         32'h0000_0013  addi x0,x0,0; driven on fetch_inst when buffer is empty
// PORTS
//  clk                 in   1   clock, rising edge
//  reset               in   1   asynchronous reset, active-low
//  inst_mem_req        out  1   request valid; address held stable until accepted
//  inst_mem_ready      in   1   memory accepts request this cycle
//  inst_mem_address    out  32  word address of request
//  inst_mem_is_valid   in   1   read data valid; earliest 1 cycle after acceptance
//  inst_mem_read_data  in   32  instruction word
//  stall               in   1   decode not accepting; head held
//  fetch_valid         out  1   FIFO head valid
//  fetch_inst          out  32  head instruction; NOP when !fetch_valid
//  inst_fetch_pc       out  32  head PC
//  redirect_valid      in   1   taken branch/jal/jalr from execute
//  redirect_pc         in   32  redirect target
//  fetch_exception     out  1   sticky misaligned-target flag
// BEHAVIOUR
//  Reset (async, any time, including mid-request): pc=RESET, state=S_IDLE, FIFO empty,
//   inst_mem_req=0, inst_mem_address=RESET, fetch_valid=0, fetch_inst=NOP, inst_fetch_pc=RESET,
//   fetch_exception=0.
//  States:
//   S_IDLE -> S_REQ on the first clock after reset release.
//   S_REQ  inst_mem_req=1 while FIFO count<FIFO_DEPTH.
//          On req&ready: req_pc<=pc, pc<=pc+4 (mod 2^32), -> S_WAIT.
//   S_WAIT on inst_mem_is_valid: push {req_pc,data}, -> S_REQ.
//   S_DROP on inst_mem_is_valid: discard data, -> S_REQ.
//   S_HALT no requests issued; exited only by reset.
//  At most one outstanding request; space is reserved at issue, so a push never meets a full FIFO.
//   Peak rate: 1 instr / 2 cycles.
//  Pop: fetch_valid && !stall at the clock edge. Push+pop in the same cycle keeps count unchanged.
//   Read/write pointers wrap modulo FIFO_DEPTH.
//  Outputs fetch_*/inst_fetch_pc are registered from FIFO storage; no combinational path from
//   memory inputs.
//  Redirect (highest priority; overrides push, pop and issue that cycle):
//   - FIFO flushed and pc<=redirect_pc.
//   - Next state: S_WAIT without inst_mem_is_valid -> S_DROP; all other states -> S_REQ.
//   - A request accepted in the same cycle is treated as in flight -> S_DROP.
//   - redirect_pc[1:0]!=0: fetch_exception<=1, -> S_HALT, FIFO flushed.
//   - Redirect while in S_DROP stays in S_DROP with the new pc.
//  inst_mem_is_valid in S_IDLE/S_REQ/S_HALT is ignored.
// CONFIGURATION
//  IFU_PERF_CNT_EN defined:
//   adds out ports perf_fetch_cnt[31:0] (+1 per push) and perf_flush_cnt[31:0] (+1 per redirect).
//   Both reset to 0 and wrap at 2^32.
//  IFU_PERF_CNT_EN undefined: ports and logic absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package ifu_pkg: state enum, NOP constant, fetch_entry_t {pc[31:0], inst[31:0]},
//   FIFO_DEPTH default.
//  Sub-module ifu_fetch_fifo: depth-parameterised FIFO with push/pop/flush, count, head outputs.
//  Top level holds the FSM, pc register and redirect logic.
// TESTING
//  1 Reset release, ready=1, 1-cycle memory returning 0x00000093,0x00100113:
//    fetch_pc 0x0 then 0x4; insts in order; first fetch_valid by cycle 3.
//  2 stall=1 for 6 cycles with ready=1: exactly 2 pushes, inst_mem_req=0 while full;
//    on release, entries pop in order with no loss.
//  3 redirect_pc=0x100 while in S_WAIT, response arrives 2 cycles later:
//    data dropped; next request address 0x100; FIFO empty after the redirect edge.
//  4 redirect_pc=0x102: fetch_exception=1 next cycle; inst_mem_req stays 0 for 20 cycles.
//  5 reset asserted mid-S_WAIT, then stale response delivered after release:
//    ignored; first request at RESET.
//  6 IFU_PERF_CNT_EN: 10 fetched + 2 redirects -> perf_fetch_cnt=10, perf_flush_cnt=2.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared state encoding, fetch-buffer entry type and defaults for the instruction fetch unit.
package ifu_pkg;

    localparam logic [31:0] IFU_NOP        = 32'h0000_0013;
    localparam int          IFU_FIFO_DEPTH = 2;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_HALT} ifu_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// ifu_fetch_fifo: power-of-2 deep {pc, inst} buffer with push/pop/flush; head is read straight from storage.
module ifu_fetch_fifo import ifu_pkg::*; #(
    parameter int DEPTH = IFU_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        wr_d  = flush ? '0 : wr_q + AW'(push);
        rd_d  = flush ? '0 : rd_q + AW'(pop);
        cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
        if (push && !flush) mem_d[wr_q] = push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // storage needs no reset: the head is only observed while count is non-zero
    always_ff @(posedge clk) mem_q <= mem_d;

    assign count = cnt_q;
    assign head  = mem_q[rd_q];

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC generator, single-outstanding instruction fetcher and fetch buffer with redirect handling.
// Optional IFU_PERF_CNT_EN adds push/redirect performance counters.
module inst_fetch_unit import ifu_pkg::*; #(
    parameter logic [31:0] RESET      = 32'h0000_0000,
    parameter int          FIFO_DEPTH = IFU_FIFO_DEPTH,
    parameter logic [31:0] NOP        = IFU_NOP
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_mem_req,
    input  logic        inst_mem_ready,
    output logic [31:0] inst_mem_address,
    input  logic        inst_mem_is_valid,
    input  logic [31:0] inst_mem_read_data,
    input  logic        stall,
    output logic        fetch_valid,
    output logic [31:0] fetch_inst,
    output logic [31:0] inst_fetch_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_exception
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e   state_q, state_d;
    logic [31:0]  pc_q, pc_d, req_pc_q, req_pc_d;
    logic         exc_q, exc_d;
    logic         push, pop, flush, accept;
    logic [CW-1:0] count;
    fetch_entry_t head;

    ifu_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({req_pc_q, inst_mem_read_data}),
        .pop       (pop),
        .flush     (flush),
        .count     (count),
        .head      (head)
    );

    // a request is only issued when a buffer slot is free, so the later push always fits
    assign inst_mem_req     = (state_q == S_REQ) && (count != CW'(FIFO_DEPTH));
    assign accept           = inst_mem_req && inst_mem_ready;
    assign inst_mem_address = pc_q;
    assign fetch_valid      = count != '0;
    assign fetch_inst       = fetch_valid ? head.inst : NOP;
    assign inst_fetch_pc    = fetch_valid ? head.pc : RESET;
    assign fetch_exception  = exc_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        exc_d    = exc_q;
        push     = 1'b0;
        pop      = fetch_valid && !stall;
        flush    = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   if (accept) begin
                         req_pc_d = pc_q;
                         pc_d     = pc_q + 32'd4;
                         state_d  = S_WAIT;
                     end
            S_WAIT:  if (inst_mem_is_valid) begin
                         push    = 1'b1;
                         state_d = S_REQ;
                     end
            S_DROP:  if (inst_mem_is_valid) state_d = S_REQ;
            default: ;
        endcase
        // redirect wins over everything; anything still in flight must be discarded in S_DROP
        if (redirect_valid && state_q != S_HALT) begin
            flush = 1'b1;
            push  = 1'b0;
            pop   = 1'b0;
            pc_d  = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                exc_d   = 1'b1;
                state_d = S_HALT;
            end else if (accept || ((state_q == S_WAIT || state_q == S_DROP) && !inst_mem_is_valid))
                state_d = S_DROP;
            else
                state_d = S_REQ;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET;
            req_pc_q <= RESET;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            exc_q    <= exc_d;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(push);
        flush_cnt_d = flush_cnt_q + 32'(redirect_valid);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed self-checking bench with a latency-configurable instruction memory model.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_mem_req;
    logic        inst_mem_ready;
    logic [31:0] inst_mem_address;
    logic        inst_mem_is_valid;
    logic [31:0] inst_mem_read_data;
    logic        stall;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic [31:0] inst_fetch_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_exception;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int lat   = 1;
    int cd    = 0;
    logic [31:0] pa;

    inst_fetch_unit dut (
        .clk                (clk),
        .reset              (reset),
        .inst_mem_req       (inst_mem_req),
        .inst_mem_ready     (inst_mem_ready),
        .inst_mem_address   (inst_mem_address),
        .inst_mem_is_valid  (inst_mem_is_valid),
        .inst_mem_read_data (inst_mem_read_data),
        .stall              (stall),
        .fetch_valid        (fetch_valid),
        .fetch_inst         (fetch_inst),
        .inst_fetch_pc      (inst_fetch_pc),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .fetch_exception    (fetch_exception)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt     (perf_fetch_cnt),
        .perf_flush_cnt     (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h0000_0093 + (a << 18) + (a << 5);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(4);
        reset = 1'b1;
    endtask

    // memory: accepts when idle, answers with rom(addr) exactly lat cycles later
    initial begin
        inst_mem_is_valid  = 1'b0;
        inst_mem_read_data = '0;
        forever begin
            @(negedge clk);
            if (inst_mem_req && inst_mem_ready && cd == 0) begin
                cd = lat;
                pa = inst_mem_address;
            end
            @(posedge clk);
            #1;
            inst_mem_is_valid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    inst_mem_is_valid  = 1'b1;
                    inst_mem_read_data = rom(pa);
                end
            end
        end
    end

    initial begin
        reset          = 1'b0;
        inst_mem_ready = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        cyc(3);
        check("rst_valid", 32'(fetch_valid), 32'd0);
        check("rst_inst", fetch_inst, 32'h0000_0013);
        check("rst_pc", inst_fetch_pc, 32'h0);
        check("rst_req", 32'(inst_mem_req), 32'd0);
        check("rst_addr", inst_mem_address, 32'h0);
        check("rst_exc", 32'(fetch_exception), 32'd0);

        // 1: basic fetch
        reset = 1'b1;
        cyc(1);
        check("t1_req", 32'(inst_mem_req), 32'd1);
        check("t1_addr", inst_mem_address, 32'h0);
        cyc(1);
        check("t1_valid_c2", 32'(fetch_valid), 32'd0);
        cyc(1);
        check("t1_valid_c3", 32'(fetch_valid), 32'd1);
        check("t1_pc0", inst_fetch_pc, 32'h0);
        check("t1_inst0", fetch_inst, 32'h0000_0093);
        cyc(1);
        check("t1_valid_c4", 32'(fetch_valid), 32'd0);
        check("t1_nop", fetch_inst, 32'h0000_0013);
        cyc(1);
        check("t1_pc1", inst_fetch_pc, 32'h4);
        check("t1_inst1", fetch_inst, 32'h0010_0113);

        // 2: stall fills the buffer, then drains in order
        stall = 1'b1;
        do_reset();
        cyc(5);
        check("t2_req_full", 32'(inst_mem_req), 32'd0);
        check("t2_head_pc", inst_fetch_pc, 32'h0);
        cyc(1);
        check("t2_req_full2", 32'(inst_mem_req), 32'd0);
        check("t2_addr", inst_mem_address, 32'h8);
        check("t2_head_inst", fetch_inst, 32'h0000_0093);
        stall = 1'b0;
        cyc(1);
        check("t2_pc4", inst_fetch_pc, 32'h4);
        check("t2_inst4", fetch_inst, 32'h0010_0113);
        check("t2_req_again", 32'(inst_mem_req), 32'd1);
        cyc(1);
        check("t2_empty", 32'(fetch_valid), 32'd0);
        cyc(1);
        check("t2_pc8", inst_fetch_pc, 32'h8);
        check("t2_inst8", fetch_inst, 32'h0020_0193);

        // 3: redirect during S_WAIT, late response dropped
        lat = 3;
        do_reset();
        cyc(2);
        check("t3_wait_req", 32'(inst_mem_req), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cyc(1);
        redirect_valid = 1'b0;
        check("t3_flushed", 32'(fetch_valid), 32'd0);
        check("t3_drop_req", 32'(inst_mem_req), 32'd0);
        cyc(1);
        check("t3_drop_req2", 32'(inst_mem_req), 32'd0);
        cyc(1);
        check("t3_req", 32'(inst_mem_req), 32'd1);
        check("t3_addr", inst_mem_address, 32'h100);
        check("t3_dropped", 32'(fetch_valid), 32'd0);
        cyc(4);
        check("t3_valid", 32'(fetch_valid), 32'd1);
        check("t3_pc", inst_fetch_pc, 32'h100);
        check("t3_inst", fetch_inst, 32'h0400_2093);

        // 4: misaligned redirect halts fetching
        lat = 1;
        do_reset();
        cyc(3);
        check("t4_valid", 32'(fetch_valid), 32'd1);
        check("t4_exc_before", 32'(fetch_exception), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        cyc(1);
        redirect_valid = 1'b0;
        check("t4_exc", 32'(fetch_exception), 32'd1);
        check("t4_flushed", 32'(fetch_valid), 32'd0);
        for (int i = 0; i < 20; i++) begin
            check("t4_halt_req", 32'(inst_mem_req), 32'd0);
            cyc(1);
        end
        check("t4_exc_sticky", 32'(fetch_exception), 32'd1);

        // 5: reset mid-S_WAIT, stale response after release is ignored
        do_reset();
        cyc(3);
        lat = 4;
        check("t5_pc0", inst_fetch_pc, 32'h0);
        cyc(1);
        reset          = 1'b0;
        inst_mem_ready = 1'b0;
        #1;
        check("t5_rst_req", 32'(inst_mem_req), 32'd0);
        check("t5_rst_addr", inst_mem_address, 32'h0);
        check("t5_rst_valid", 32'(fetch_valid), 32'd0);
        check("t5_rst_exc", 32'(fetch_exception), 32'd0);
        cyc(1);
        reset = 1'b1;
        cyc(1);
        check("t5_req", 32'(inst_mem_req), 32'd1);
        check("t5_addr", inst_mem_address, 32'h0);
        cyc(1);
        check("t5_stale_ign", 32'(fetch_valid), 32'd0);
        check("t5_addr2", inst_mem_address, 32'h0);
        inst_mem_ready = 1'b1;
        lat            = 1;
        cyc(1);
        check("t5_stale_ign2", 32'(fetch_valid), 32'd0);
        cyc(1);
        check("t5_valid", 32'(fetch_valid), 32'd1);
        check("t5_pc", inst_fetch_pc, 32'h0);
        check("t5_inst", fetch_inst, 32'h0000_0093);

`ifdef IFU_PERF_CNT_EN
        // 6: performance counters
        do_reset();
        check("t6_rst_fetch", perf_fetch_cnt, 32'd0);
        check("t6_rst_flush", perf_flush_cnt, 32'd0);
        cyc(21);
        check("t6_fetch10", perf_fetch_cnt, 32'd10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cyc(1);
        redirect_pc    = 32'h300;
        cyc(1);
        redirect_valid = 1'b0;
        check("t6_fetch", perf_fetch_cnt, 32'd10);
        check("t6_flush", perf_flush_cnt, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
